// File: rtl/mux4_bus_arbiter_pkg.sv
// Shared types and helpers for the 4-way bus arbiter.
// Requester count, FSM state encoding and one-hot to index encoder.
package mux4_bus_arbiter_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   function automatic logic [1:0] encode4(input logic [N_REQ-1:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux4_bus_arbiter_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr.
// Search wraps from requester 3 back to requester 0.
module rr_pick4
   import mux4_bus_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [N_REQ-1:0] gnt,
   output logic             any
);

   logic [1:0] idx;

   always_comb begin
      gnt = '0;
      idx = ptr;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + 2'(k);
         if ((gnt == '0) && req[idx]) gnt[idx] = 1'b1;
      end
   end

   assign any = |req;

endmodule

// File: rtl/mux4_bus_arbiter.sv
// Round-robin burst arbiter driving the select of a shared 4:1 bus mux.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module mux4_bus_arbiter
   import mux4_bus_arbiter_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             out_ready,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       sel,
   output logic             out_valid,
   output logic [N_REQ-1:0] beat_ack,
   output logic             busy
);

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;

   logic             owner_req;
   logic             beat;
   logic             last_beat;
   logic             release_own;
   logic [1:0]       next_ptr;
   logic [1:0]       pick_ptr;
   logic [N_REQ-1:0] pick_gnt;
   logic             pick_any;

   assign owner_req = |(req & grant_q);
   assign busy      = (state_q == ST_GRANT);
   // Reset abandons the burst immediately, so no beat is signalled this cycle.
   assign out_valid = busy && owner_req && !rst;
   assign beat      = out_valid && out_ready;
   assign beat_ack  = beat ? grant_q : '0;
   assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
   assign release_own = busy && (!owner_req || (beat && last_beat));

`ifdef ARB_FIXED_PRIO_EN
   assign next_ptr = 2'd0;
`else
   assign next_ptr = sel_q + 2'd1;
`endif

   // On release the handover pick already sees the updated pointer.
   assign pick_ptr = release_own ? next_ptr : rr_ptr_q;

   rr_pick4 u_pick (
      .req (req),
      .ptr (pick_ptr),
      .gnt (pick_gnt),
      .any (pick_any)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_gnt;
               sel_d   = encode4(pick_gnt);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (release_own) begin
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
               if (pick_any) begin
                  grant_d = pick_gnt;
                  sel_d   = encode4(pick_gnt);
               end else begin
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
            end else if (beat) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         sel_q      <= 2'd0;
         beat_cnt_q <= '0;
         rr_ptr_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Bench for mux4_bus_arbiter: directed scenarios then random traffic,
// every cycle compared against an integer-level reference model.
module tb_mux4_bus_arbiter;

   localparam int BL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       out_ready;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       out_valid;
   logic [3:0] beat_ack;
   logic       busy;

   int vectors = 0;
   int errs    = 0;

   int m_owner;
   int m_ptr;
   int m_cnt;
   int m_sel;

   always #5 clk = ~clk;

   mux4_bus_arbiter #(.BURST_LEN(BL), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
      .grant     (grant),
      .sel       (sel),
      .out_valid (out_valid),
      .beat_ack  (beat_ack),
      .busy      (busy)
   );

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h at %0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
      logic [3:0] e_grant;
      logic       e_valid;
      logic       e_beat;
      logic       rel;
      @(negedge clk);
      req       = r;
      out_ready = rdy;
      rst       = rs;
      #1;
      e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      e_valid = (m_owner >= 0) && r[m_owner] && !rs;
      e_beat  = e_valid && rdy;
      chk("grant", grant, e_grant);
      chk("sel", {2'b0, sel}, 4'(m_sel));
      chk("busy", {3'b0, busy}, {3'b0, m_owner >= 0});
      chk("out_valid", {3'b0, out_valid}, {3'b0, e_valid});
      chk("beat_ack", beat_ack, e_beat ? e_grant : 4'b0);
      if (rs) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
      end else if (m_owner < 0) begin
         m_owner = pick(r, m_ptr);
         if (m_owner >= 0) m_sel = m_owner;
      end else begin
         rel = !r[m_owner] || (e_beat && (m_cnt + 1 == BL));
         if (e_beat) m_cnt++;
         if (rel) begin
`ifdef ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (m_owner + 1) % 4;
`endif
            m_cnt = 0;
            m_owner = pick(r, m_ptr);
            if (m_owner >= 0) m_sel = m_owner;
         end
      end
   endtask

   initial begin
      req = '0; out_ready = 1'b0; rst = 1'b1;
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      // single requester burst, then drop
      for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      chk("t1_idle", grant, 4'b0000);
      // all requesting, rotation with direct handoffs
      for (int i = 0; i < 22; i++) step(4'b1111, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      // owner 1 stalled, then drops with 2 pending
      step(4'b0010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(4'b0110, 1'b0, 1'b0);
      chk("t3_hold", grant, 4'b0010);
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      chk("t3_handoff", grant, 4'b0100);
      // reset mid-burst
      step(4'b0000, 1'b0, 1'b1);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b1);
      step(4'b1010, 1'b0, 1'b0);
      chk("t4_rst_grant", grant, 4'b0000);
      step(4'b1010, 1'b0, 1'b0);
      chk("t4_first", grant, 4'b0010);
      // lone requester regranted back-to-back
      step(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 14; i++) step(4'b1000, 1'b1, 1'b0);
      // random traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) == 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
